// File: rtl/xalu_ise_issue_pkg.sv
// Shared constants for the xalu_ise custom-instruction issuer:
// custom opcode encodings, instruction field positions and FSM state codes.
package xalu_ise_issue_pkg;

    localparam logic [6:0] CUSTOM_0 = 7'h0B;
    localparam logic [6:0] CUSTOM_1 = 7'h2B;
    localparam logic [6:0] CUSTOM_2 = 7'h5B;
    localparam logic [6:0] CUSTOM_3 = 7'h7B;

    // All four custom-x opcodes share insn[4:0] == 5'b01011
    localparam logic [6:0] CUSTOM_OPC_MASK = 7'h1F;
    localparam logic [6:0] CUSTOM_OPC_VAL  = 7'h0B;

    localparam int FUNCT7_HI = 31;
    localparam int FUNCT7_LO = 25;
    localparam int FUNCT3_HI = 14;
    localparam int FUNCT3_LO = 12;
    localparam int RD_HI     = 11;
    localparam int RD_LO     = 7;
    localparam int OPC_HI    = 6;
    localparam int OPC_LO    = 0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/xalu_ise_issue_dec.sv
// Combinational decode of a raw instruction word into the fields driven
// towards the ISE unit and back to writeback.
module xalu_ise_issue_dec
    import xalu_ise_issue_pkg::*;
(
    input  logic [31:0] insn,
    output logic        is_custom,
    output logic [4:0]  fn,
    output logic [6:0]  imm,
    output logic [4:0]  rd
);

    logic [6:0] opc_s;
    logic       unused_s;

    assign opc_s     = insn[OPC_HI:OPC_LO];
    assign is_custom = ((opc_s & CUSTOM_OPC_MASK) == CUSTOM_OPC_VAL);
    assign fn        = {insn[FUNCT3_HI:FUNCT3_LO], opc_s[6:5]};
    assign imm       = insn[FUNCT7_HI:FUNCT7_LO];
    assign rd        = insn[RD_HI:RD_LO];

    // rs1/rs2 register indices are not needed: operand values arrive separately
    assign unused_s  = ^insn[24:15];

endmodule

// File: rtl/xalu_ise_issue.sv
// Core-side issuer for the xalu_ise custom-instruction port: one instruction in
// flight, ISE request with timeout, and a held response towards writeback.
module xalu_ise_issue
    import xalu_ise_issue_pkg::*;
#(
    parameter int TIMEOUT = 8,
    parameter int CNT_W   = 4
) (
    input  logic        ise_clk,
    input  logic        ise_rst,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_insn,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,
    output logic        ise_val,
    output logic [4:0]  ise_fn,
    output logic [6:0]  ise_imm,
    output logic [31:0] ise_in1,
    output logic [31:0] ise_in2,
    input  logic        ise_oval,
    input  logic [31:0] ise_out,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [4:0]  rsp_rd,
    output logic        rsp_wen,
    output logic [31:0] rsp_data,
    output logic        rsp_illegal
);

    logic [1:0]       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             dec_custom_s;
    logic [4:0]       dec_fn_s;
    logic [6:0]       dec_imm_s;
    logic [4:0]       dec_rd_s;
    logic             timeout_s;

    xalu_ise_issue_dec u_dec (
        .insn      (req_insn),
        .is_custom (dec_custom_s),
        .fn        (dec_fn_s),
        .imm       (dec_imm_s),
        .rd        (dec_rd_s)
    );

    // Depends only on registered state and flush, never on rsp_ready
    assign req_ready = (state_r == ST_IDLE) && !flush;
    assign timeout_s = (cnt_r == CNT_W'(TIMEOUT - 1));

    // Issue FSM, wait counter, ISE request registers and response registers
    always_ff @(posedge ise_clk) begin
        if (ise_rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= '0;
            ise_val     <= 1'b0;
            ise_fn      <= 5'd0;
            ise_imm     <= 7'd0;
            ise_in1     <= 32'd0;
            ise_in2     <= 32'd0;
            rsp_valid   <= 1'b0;
            rsp_rd      <= 5'd0;
            rsp_wen     <= 1'b0;
            rsp_data    <= 32'd0;
            rsp_illegal <= 1'b0;
        end else if (flush) begin
            state_r   <= ST_IDLE;
            cnt_r     <= '0;
            ise_val   <= 1'b0;
            rsp_valid <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        ise_fn  <= dec_fn_s;
                        ise_imm <= dec_imm_s;
                        ise_in1 <= req_rs1;
                        ise_in2 <= req_rs2;
                        rsp_rd  <= dec_rd_s;
                        cnt_r   <= '0;
                        if (dec_custom_s) begin
                            state_r <= ST_BUSY;
                            ise_val <= 1'b1;
                        end else begin
                            // Not a custom-x opcode: report illegal without touching the ISE
                            state_r     <= ST_RESP;
                            rsp_valid   <= 1'b1;
                            rsp_illegal <= 1'b1;
                            rsp_wen     <= 1'b0;
                            rsp_data    <= 32'd0;
                        end
                    end
                end
                ST_BUSY: begin
                    if (ise_oval) begin
                        state_r     <= ST_RESP;
                        ise_val     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_illegal <= 1'b0;
                        rsp_wen     <= (rsp_rd != 5'd0);
                        rsp_data    <= ise_out;
                    end else if (timeout_s) begin
                        state_r     <= ST_RESP;
                        ise_val     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_illegal <= 1'b1;
                        rsp_wen     <= 1'b0;
                        rsp_data    <= 32'd0;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state_r   <= ST_IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    cnt_r     <= '0;
                    ise_val   <= 1'b0;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
